// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - word RAM slave with LAT-cycle access latency; RAM_RESPONDER_ERRCHK_EN enables request error checking
package cpu_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int DEPTH = 16384
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output ramstate_t   ramstate
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAST = 4'(LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state, next_state;
    logic [3:0]  cnt, next_cnt, cur;
    logic [33:0] cap_op, next_cap, op;
    logic        req, same_op, err, is_write, is_read;
    logic        commit, load;
    logic [AW-1:0] widx;

    logic [31:0] mem [DEPTH] = '{default: '0};

    assign op       = {ramREN, ramWEN, ramaddr};
    assign req      = ramREN | ramWEN;
    assign same_op  = (state != IDLE) && (op == cap_op);
    assign is_write = ramWEN;
    assign is_read  = ramREN & ~ramWEN;

`ifdef RAM_RESPONDER_ERRCHK_EN
    assign err  = req && ((ramREN && ramWEN) || (ramaddr[1:0] != 2'b00) ||
                          (ramaddr[31:2] >= 30'(DEPTH)));
    assign widx = ramaddr[AW+1:2];
`else
    assign err  = 1'b0;
    assign widx = AW'(ramaddr[31:2] % 30'(DEPTH));
`endif

    // cur is the index of the present cycle within the current op; any op change restarts it at 0
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_cap   = cap_op;
        cur        = 4'd0;
        commit     = 1'b0;
        load       = 1'b0;
        ramstate   = FREE;
        if (!req) begin
            next_state = IDLE;
            next_cnt   = 4'd0;
        end else if (err) begin
            ramstate   = ERROR;
            next_state = IDLE;
            next_cnt   = 4'd0;
        end else if (state == DONE && same_op) begin
            ramstate = ACCESS;
            commit   = is_write;
            load     = is_read;
        end else begin
            ramstate = BUSY;
            next_cap = op;
            cur      = (state == WAIT && same_op) ? cnt : 4'd0;
            if (cur == LAST) begin
                next_state = DONE;
                commit     = is_write;
                load       = is_read;
            end else begin
                next_state = WAIT;
                next_cnt   = cur + 4'd1;
            end
        end
        // Reset overrides everything, including a commit due on this edge
        if (!nRST) begin
            ramstate = FREE;
            commit   = 1'b0;
            load     = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            cap_op  <= '0;
            ramload <= '0;
        end else begin
            state  <= next_state;
            cnt    <= next_cnt;
            cap_op <= next_cap;
            if (load) begin
                ramload <= mem[widx];
            end
        end
    end

    // Memory contents survive reset
    always_ff @(posedge CLK) begin
        if (commit) begin
            mem[widx] <= ramstore;
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - vector table plus randomized model comparison for ram_responder
module tb_ram_responder;
    import cpu_types_pkg::*;

    localparam int LAT = 2;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ramREN = 1'b0;
    logic        ramWEN = 1'b0;
    logic [31:0] ramaddr = '0;
    logic [31:0] ramstore = '0;
    logic [31:0] ramload;
    ramstate_t   ramstate;

    int checks = 0;
    int errors = 0;

    ram_responder #(.LAT(LAT), .DEPTH(16384)) dut (
        .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst_n;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] data;
        ramstate_t   st;
        logic        chk;
        logic [31:0] ld;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] mem_m [int];

    function automatic void add(logic r, logic ren, logic wen, logic [31:0] a, logic [31:0] d,
                                ramstate_t st, logic chk, logic [31:0] ld);
        vec_t v;
        v.rst_n = r; v.ren = ren; v.wen = wen; v.addr = a; v.data = d;
        v.st = st; v.chk = chk; v.ld = ld;
        vecs.push_back(v);
    endfunction

    function automatic void op3(logic ren, logic wen, logic [31:0] a, logic [31:0] d,
                                logic chk, logic [31:0] ld);
        add(1'b1, ren, wen, a, d, BUSY, 1'b0, '0);
        add(1'b1, ren, wen, a, d, BUSY, 1'b0, '0);
        add(1'b1, ren, wen, a, d, ACCESS, chk, ld);
    endfunction

    function automatic void drop();
        add(1'b1, 1'b0, 1'b0, '0, '0, FREE, 1'b0, '0);
    endfunction

    function automatic logic [31:0] rd_m(int a);
        return mem_m.exists(a) ? mem_m[a] : 32'h0;
    endfunction

    task automatic check_state(string name, ramstate_t exp);
        checks++;
        if (ramstate !== exp) begin
            errors++;
            $display("FAIL %s state: got %s expected %s", name, ramstate.name(), exp.name());
        end
    endtask

    task automatic check_load(string name, logic [31:0] exp);
        checks++;
        if (ramload !== exp) begin
            errors++;
            $display("FAIL %s ramload: got %h expected %h", name, ramload, exp);
        end
    endtask

    initial begin
        // Directed table
        add(1'b0, 1'b0, 1'b0, '0, '0, FREE, 1'b1, 32'h0);
        add(1'b0, 1'b1, 1'b0, '0, '0, FREE, 1'b1, 32'h0);
        op3(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, '0);
        op3(1'b1, 1'b0, 32'h10, '0, 1'b1, 32'hDEADBEEF);
        drop();
        add(1'b1, 1'b0, 1'b1, 32'h14, 32'hFEEDFEED, BUSY, 1'b0, '0);
        op3(1'b0, 1'b1, 32'h18, 32'hFEEDFEED, 1'b0, '0);
        drop();
        op3(1'b1, 1'b0, 32'h14, '0, 1'b1, 32'h0);
        drop();
        op3(1'b1, 1'b0, 32'h18, '0, 1'b1, 32'hFEEDFEED);
        op3(1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, '0);
        op3(1'b1, 1'b0, 32'h20, '0, 1'b1, 32'hA5A5A5A5);
        for (int k = 0; k < 3; k++) add(1'b1, 1'b1, 1'b0, 32'h20, '0, ACCESS, 1'b1, 32'hA5A5A5A5);
        add(1'b1, 1'b0, 1'b0, '0, '0, FREE, 1'b1, 32'hA5A5A5A5);
        add(1'b1, 1'b0, 1'b1, 32'h24, 32'h12345678, BUSY, 1'b0, '0);
        add(1'b0, 1'b0, 1'b1, 32'h24, 32'h12345678, FREE, 1'b1, 32'h0);
        add(1'b1, 1'b0, 1'b0, '0, '0, FREE, 1'b1, 32'h0);
        op3(1'b1, 1'b0, 32'h24, '0, 1'b1, 32'h0);
        op3(1'b1, 1'b0, 32'h10, '0, 1'b1, 32'hDEADBEEF);
        drop();
`ifdef RAM_RESPONDER_ERRCHK_EN
        add(1'b1, 1'b1, 1'b0, 32'h11, '0, ERROR, 1'b0, '0);
        add(1'b1, 1'b1, 1'b0, 32'h11, '0, ERROR, 1'b0, '0);
        add(1'b1, 1'b1, 1'b1, 32'h10, '0, ERROR, 1'b0, '0);
        add(1'b1, 1'b1, 1'b0, 32'h10000, '0, ERROR, 1'b0, '0);
        drop();
`else
        op3(1'b1, 1'b0, 32'h10011, '0, 1'b1, 32'hDEADBEEF);
        drop();
`endif
        for (int a = 0; a <= 32'h28; a += 4) op3(1'b0, 1'b1, 32'(a), 32'(a * 16), 1'b0, '0);
        for (int a = 0; a <= 32'h28; a += 4) op3(1'b1, 1'b0, 32'(a), '0, 1'b1, 32'(a * 16));
        add(1'b0, 1'b1, 1'b0, 32'h4, '0, FREE, 1'b1, 32'h0);
        op3(1'b1, 1'b0, 32'h4, '0, 1'b1, 32'h40);
        drop();

        foreach (vecs[i]) begin
            @(posedge CLK);
            #1;
            nRST = vecs[i].rst_n; ramREN = vecs[i].ren; ramWEN = vecs[i].wen;
            ramaddr = vecs[i].addr; ramstore = vecs[i].data;
            @(negedge CLK);
            check_state($sformatf("vec%0d", i), vecs[i].st);
            if (vecs[i].chk) check_load($sformatf("vec%0d", i), vecs[i].ld);
        end

        // Randomized phase on words untouched by the table, against an age-based model
        begin
            logic        ren, wen, pren, pwen, preq, req;
            logic [31:0] addr, data, paddr, last_load;
            int          age, hold;
            ramstate_t   exp;
            ren = 0; wen = 0; addr = 0; data = 0;
            pren = 0; pwen = 0; paddr = 0; preq = 0;
            age = 0; hold = 0;
            @(posedge CLK); #1;
            nRST = 0; ramREN = 0; ramWEN = 0;
            @(posedge CLK); #1;
            nRST = 1;
            last_load = 32'h0;
            for (int i = 0; i < 600; i++) begin
                @(posedge CLK);
                #1;
                if (hold == 0) begin
                    int r;
                    r = $urandom_range(0, 9);
                    ren = (r >= 2 && r < 6);
                    wen = (r >= 6);
                    addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
                    data = $urandom;
                    hold = $urandom_range(1, 5);
                end
                hold--;
                ramREN = ren; ramWEN = wen; ramaddr = addr; ramstore = data;
                @(negedge CLK);
                req = ren | wen;
                if (req && preq && ren == pren && wen == pwen && addr == paddr) age++;
                else age = req ? 1 : 0;
                exp = !req ? FREE : (age > LAT ? ACCESS : BUSY);
                check_state($sformatf("rnd%0d", i), exp);
                check_load($sformatf("rnd%0d", i), last_load);
                if (req && age >= LAT) begin
                    if (wen) mem_m[int'(addr[31:2])] = data;
                    else     last_load = rd_m(int'(addr[31:2]));
                end
                preq = req; pren = ren; pwen = wen; paddr = addr;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning wait cycles before ACCESS; legal range 1..15.
REQ-002 SHALL have parameter DEPTH, default 16384, meaning number of 32-bit words stored.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port nRST, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port ramREN, input, 1, read request level.
REQ-006 SHALL have port ramWEN, input, 1, write request level.
REQ-007 SHALL have port ramaddr, input, 32, byte address; word index = ramaddr[31:2].
REQ-008 SHALL have port ramstore, input, 32, write data.
REQ-009 SHALL have port ramload, output, 32, read data.
REQ-010 SHALL have port ramstate, output, ramstate_t (cpu_types_pkg), one of FREE/BUSY/ACCESS/ERROR.

Function
REQ-011 SHALL implement states IDLE, WAIT, DONE, plus a wait counter of 4 bits.
REQ-012 SHALL treat "request" as ramREN|ramWEN; "op" as {ramREN,ramWEN,ramaddr}, captured on entry to WAIT.
REQ-013 SHALL drive ramstate=FREE combinationally when no request is present, in any state.
REQ-014 SHALL, for a request first presented in cycle 0, drive BUSY in cycles 0..LAT-1 and ACCESS in cycle LAT, provided the op is unchanged.
REQ-015 SHALL commit a write into memory at the clock edge ending cycle LAT-1, so that ACCESS is reported in the cycle the data is visible.
REQ-016 SHALL present read data on ramload, registered, valid throughout every ACCESS cycle of a read; ramload holds its last value otherwise.
REQ-017 SHALL remain in DONE with ramstate=ACCESS while the same op is held; a held write is not re-counted and re-commits identical data harmlessly.
REQ-018 SHALL, on any op change (address, enable, or REN/WEN swap) in WAIT or DONE, restart the counter and report BUSY for LAT cycles; a write aborted before commit is not committed.
REQ-019 SHALL return to IDLE when the request is dropped in any state; a write dropped before commit is discarded.
REQ-020 SHALL make a read in ACCESS the cycle after a committed write to the same word return the new data (read-after-write coherent).
REQ-021 SHALL not clear memory contents on reset; uninitialised words read as 0 (memory zero-initialised at time zero).

Reset
REQ-022 SHALL, while nRST=0, force state IDLE, counter 0, ramload 0, captured op 0, and ramstate=FREE regardless of inputs.
REQ-023 SHALL, on reset asserted mid-WAIT of a write, not commit that write.
REQ-024 SHALL, on nRST release with a request present, treat the next cycle as cycle 0 of a new request.

Configuration
REQ-025 SHALL support macro RAM_RESPONDER_ERRCHK_EN.
REQ-026 SHALL, with RAM_RESPONDER_ERRCHK_EN defined, drive ramstate=ERROR combinationally and perform no access when: ramREN&ramWEN, ramaddr[1:0]!=0, or word index >= DEPTH; ERROR persists while the condition holds; the state returns to IDLE.
REQ-027 SHALL, without RAM_RESPONDER_ERRCHK_EN, ignore ramaddr[1:0], wrap the word index modulo DEPTH, treat REN&WEN as a write, and never drive ERROR.

Verification (LAT=2, DEPTH=16384)
REQ-028 SHALL cover: reset, write 0x0000_0010 <- 0xDEADBEEF held -> BUSY,BUSY,ACCESS; then read 0x10 -> BUSY,BUSY,ACCESS with ramload=0xDEADBEEF.
REQ-029 SHALL cover: write 0x14 <- 0xFEEDFEED, address changed to 0x18 after 1 BUSY cycle -> counter restarts (2 more BUSY); read 0x14 returns 0, read 0x18 returns 0xFEEDFEED.
REQ-030 SHALL cover: read 0x20 held 6 cycles -> BUSY,BUSY then ACCESS for 4 cycles with stable ramload; drop request -> FREE next cycle.
REQ-031 SHALL cover: nRST pulsed low during cycle 1 of write 0x24 <- 0x12345678 -> ramstate FREE, ramload 0; later read 0x24 returns 0; earlier write at 0x10 still reads 0xDEADBEEF.
REQ-032 SHALL cover with RAM_RESPONDER_ERRCHK_EN: ramaddr=0x11 read -> ERROR; REN&WEN -> ERROR; ramaddr=0x10000 -> ERROR; without macro, read 0x10011 returns word 0x10's data after 2 BUSY cycles.
REQ-033 SHALL cover: back-to-back writes to 0x0..0x28 step 4 with data addr*16, then reads of same -> each returns addr*16.
